// File: rtl/banked_data_mem_pkg.sv
// banked_data_mem_pkg: shared types and lane-rotation helpers for the banked data memory
package banked_data_mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;
  typedef enum logic [1:0] {NORMAL, DEBUG, CLEAR} state_e;
  function automatic int size_bytes(logic [1:0] sz, int lanes);
    return sz == SZ_BYTE ? 1 : sz == SZ_HALF ? 2 : lanes;
  endfunction
  function automatic int lane_of(int sh, int i, int lanes);
    return (sh + i) % lanes;
  endfunction
  // byte index of the access that a given lane carries
  function automatic int unrotate(int lane, int sh, int lanes);
    return (lane - sh + lanes) % lanes;
  endfunction
endpackage

// File: rtl/banked_data_mem_if.sv
// banked_data_mem_if: request/response bus of the banked data memory
interface banked_data_mem_if #(parameter int ADDR_W = 32, parameter int WORD_W = 32);
  logic req_valid, req_ready, req_we, req_signed;
  logic [1:0] req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata, rsp_rdata;
  logic rsp_valid, rsp_err;
  modport master (output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/banked_data_mem_dpram_lane.sv
// dpram_lane: one byte-wide bank, port 1 read/write, port 2 write-only, write-first
module dpram_lane #(parameter int DEPTH = 1024, localparam int AW = $clog2(DEPTH)) (
  input  logic          clk,
  input  logic          en1,
  input  logic          we1,
  input  logic [AW-1:0] a1,
  input  logic [7:0]    d1,
  output logic [7:0]    q1,
  input  logic          we2,
  input  logic [AW-1:0] a2,
  input  logic [7:0]    d2
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we1) mem[a1] <= d1;
    if (we2) mem[a2] <= d2;
    if (en1) q1 <= we1 ? d1 : mem[a1];
  end
endmodule

// File: rtl/banked_data_mem.sv
// banked_data_mem: byte-banked memory with unaligned access, debug loader and clear engine
module banked_data_mem import banked_data_mem_pkg::*; #(
  parameter int LANES  = 4,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int WORD_W = LANES * 8
) (
  input  logic              Clk,
  input  logic              Reset,
  banked_data_mem_if.slave  bus,
  input  logic              dbg_enable,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [WORD_W-1:0] dbg_data1,
  input  logic [WORD_W-1:0] dbg_data2,
  input  logic              clr_start,
  output logic              clr_busy
);
  localparam int LW = $clog2(LANES), EW = $clog2(DEPTH), BW = LW + EW;
  state_e state, state_n;
  logic [EW-2:0] cnt;
  logic [BW-1:0] ba;
  logic [BW:0] last;
  logic [LW-1:0] sh, r_sh;
  logic [LW:0] nb, r_nb;
  logic [EW-1:0] ent, dw;
  logic err, acc, r_rd, r_sgn, msb;
  logic [WORD_W-1:0] rd, rdata;
  logic unused_ok;
  assign ba = bus.req_addr[BW-1:0];
  assign sh = ba[LW-1:0];
  assign ent = ba[BW-1:LW];
  assign dw = dbg_addr[BW-1:LW];
  assign nb = (LW+1)'(size_bytes(bus.req_size, LANES));
  assign last = {1'b0, ba} + (BW+1)'(nb) - (BW+1)'(1);
  assign err = bus.req_size == 2'b11 || last[BW];
  assign bus.req_ready = state == NORMAL && !clr_start;
  assign acc = bus.req_valid && bus.req_ready;
  assign clr_busy = state == CLEAR;
  assign unused_ok = ^{bus.req_addr[ADDR_W-1:BW], dbg_addr[ADDR_W-1:BW], dbg_addr[LW-1:0], last[BW-1:0]};
  always_comb begin
    state_n = state;
    state_n = state == CLEAR ? (cnt == '1 ? (dbg_enable ? DEBUG : NORMAL) : CLEAR)
                             : clr_start ? CLEAR : dbg_enable ? DEBUG : NORMAL;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= NORMAL;
      cnt <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      r_rd <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == CLEAR ? cnt + (EW-1)'(1) : '0;
      bus.rsp_valid <= acc;
      bus.rsp_err <= acc && err;
      r_rd <= acc && !bus.req_we && !err;
    end
    r_sh <= sh;
    r_nb <= nb;
    r_sgn <= bus.req_signed;
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LW-1:0] k;
    logic [EW-1:0] a1, a2;
    logic [7:0] d1, d2;
    logic we1, we2;
    assign k = LW'(unrotate(l, int'(sh), LANES));
    // lanes below the start offset hold bytes that spill into the next entry
    assign a1 = state == CLEAR ? {cnt, 1'b0} : state == DEBUG ? dw : ent + EW'(l < int'(sh));
    assign a2 = state == CLEAR ? {cnt, 1'b1} : dw + EW'(1);
    assign we1 = state == CLEAR || (state == DEBUG && dbg_valid)
              || (acc && bus.req_we && !err && {1'b0, k} < nb);
    assign we2 = state == CLEAR || (state == DEBUG && dbg_valid && dw != '1);
    assign d1 = state == NORMAL ? bus.req_wdata[8*k +: 8] : state == DEBUG ? dbg_data1[8*l +: 8] : 8'h00;
    assign d2 = state == CLEAR ? 8'h00 : dbg_data2[8*l +: 8];
    dpram_lane #(.DEPTH(DEPTH)) u_lane (
      .clk(Clk), .en1(we1 || acc), .we1(we1), .a1(a1), .d1(d1), .q1(rd[8*l +: 8]),
      .we2(we2), .a2(a2), .d2(d2)
    );
  end
  always_comb begin
    msb = r_sgn && rd[8*lane_of(int'(r_sh), int'(r_nb) - 1, LANES) + 7];
    rdata = '0;
    for (int i = 0; i < LANES; i++)
      rdata[8*i +: 8] = i < int'(r_nb) ? rd[8*lane_of(int'(r_sh), i, LANES) +: 8] : {8{msb}};
    bus.rsp_rdata = r_rd ? rdata : '0;
  end
endmodule

// File: tb/tb_banked_data_mem.sv
// tb_banked_data_mem: directed and random checks of banked_data_mem against a byte-array model
module tb_banked_data_mem;
  logic Clk = 0, Reset = 1;
  logic dbg_enable = 0, dbg_valid = 0, clr_start = 0, clr_busy;
  logic [31:0] dbg_addr = 0, dbg_data1 = 0, dbg_data2 = 0;
  logic [7:0] mm [4096];
  int vectors = 0, miscompares = 0;
  banked_data_mem_if #(.ADDR_W(32), .WORD_W(32)) bus ();
  banked_data_mem dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .dbg_enable(dbg_enable), .dbg_valid(dbg_valid),
    .dbg_addr(dbg_addr), .dbg_data1(dbg_data1), .dbg_data2(dbg_data2),
    .clr_start(clr_start), .clr_busy(clr_busy)
  );
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] ed, output logic ee);
    int nb = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    int base = int'(a[11:0]);
    ee = sz == 3 || base + nb - 1 >= 4096;
    ed = 0;
    if (!ee) begin
      if (we) for (int i = 0; i < nb; i++) mm[base+i] = wd[8*i +: 8];
      else begin
        for (int i = 0; i < nb; i++) ed[8*i +: 8] = mm[base+i];
        if (sg) for (int i = nb; i < 4; i++) ed[8*i +: 8] = {8{mm[base+nb-1][7]}};
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n = 0;
    logic [31:0] ed;
    logic ee;
    @(negedge Clk);
    bus.req_valid = 1; bus.req_we = we; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    while (!bus.req_ready && n < 2000) begin @(negedge Clk); n++; end
    chk("req_ready", bus.req_ready, 1);
    model(we, sz, sg, a, wd, ed, ee);
    @(posedge Clk); #1;
    bus.req_valid = 0;
    rd = bus.rsp_rdata; er = bus.rsp_err;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_err", er, ee);
    chk("rsp_rdata", rd, ed);
  endtask

  task automatic dbg_load(input logic [31:0] a, input logic [31:0] d1, input logic [31:0] d2);
    int w = int'(a[11:2]) * 4;
    @(negedge Clk) dbg_enable = 1;
    @(negedge Clk) begin dbg_valid = 1; dbg_addr = a; dbg_data1 = d1; dbg_data2 = d2; end
    @(negedge Clk) begin dbg_valid = 0; dbg_enable = 0; end
    for (int i = 0; i < 4; i++) begin
      mm[w+i] = d1[8*i +: 8];
      if (w != 4092) mm[w+4+i] = d2[8*i +: 8];
    end
  endtask

  initial begin
    logic [31:0] rd, ed, v600;
    logic er, ee;
    int n, bad;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_ready", bus.req_ready, 1);
    // full clear gives the model a known starting image
    @(negedge Clk) clr_start = 1;
    @(posedge Clk); #1 clr_start = 0;
    n = 0; bad = 0;
    while (clr_busy && n < 2000) begin n++; if (bus.req_ready) bad = 1; @(posedge Clk); #1; end
    chk("clr_cycles", n, 512);
    chk("clr_ready_low", bad, 0);
    for (int i = 0; i < 4096; i++) mm[i] = 0;
    dbg_load(32'h0, 32'h44332211, 32'h88776655);
    do_req(0, 2, 0, 32'h0, 0, rd, er); chk("dbg_word0", rd, 32'h44332211);
    do_req(0, 2, 0, 32'h4, 0, rd, er); chk("dbg_word4", rd, 32'h88776655);
    do_req(0, 2, 0, 32'h3, 0, rd, er); chk("unal_word3", rd, 32'h77665544);
    do_req(0, 1, 1, 32'h1, 0, rd, er); chk("shalf1", rd, 32'h00003322);
    do_req(0, 0, 1, 32'h7, 0, rd, er); chk("sbyte7", rd, 32'hFFFFFF88);
    do_req(1, 1, 0, 32'h3, 32'hBEEF, rd, er); chk("half_wr_rdata", rd, 0);
    do_req(0, 2, 0, 32'h0, 0, rd, er); chk("after_half0", rd, 32'hEF332211);
    do_req(0, 2, 0, 32'h4, 0, rd, er); chk("after_half4", rd, 32'h887766BE);
    do_req(0, 2, 0, 32'hFFD, 0, rd, er); chk("oob_rd_err", er, 1); chk("oob_rd_data", rd, 0);
    do_req(1, 2, 0, 32'hFFC, 32'h13579BDF, rd, er);
    do_req(1, 2, 0, 32'hFFD, 32'hFFFFFFFF, rd, er); chk("oob_wr_err", er, 1);
    do_req(0, 2, 0, 32'hFFC, 0, rd, er); chk("oob_wr_unchanged", rd, 32'h13579BDF);
    do_req(0, 0, 0, 32'hFFF, 0, rd, er); chk("top_byte_err", er, 0); chk("top_byte", rd, 32'h13);
    dbg_load(32'hFFE, 32'hCAFEF00D, 32'h0BADBEEF);
    do_req(0, 2, 0, 32'hFFC, 0, rd, er); chk("dbg_top", rd, 32'hCAFEF00D);
    do_req(0, 2, 0, 32'h0, 0, rd, er); chk("dbg_no_wrap", rd, 32'hEF332211);
    dbg_load(32'h102, 32'h01020304, 32'hA0B0C0D0);
    do_req(0, 2, 0, 32'h100, 0, rd, er); chk("dbg_align1", rd, 32'h01020304);
    do_req(0, 2, 0, 32'h104, 0, rd, er); chk("dbg_align2", rd, 32'hA0B0C0D0);
    // back-to-back write then read of the same word
    @(negedge Clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2; bus.req_signed = 0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'hA5C30F96;
    model(1, 2, 0, 32'h21, 32'hA5C30F96, ed, ee);
    @(posedge Clk); #1 bus.req_we = 0;
    chk("b2b_wr_valid", bus.rsp_valid, 1);
    chk("b2b_wr_rdata", bus.rsp_rdata, 0);
    @(posedge Clk); #1 bus.req_valid = 0;
    chk("b2b_rd_valid", bus.rsp_valid, 1);
    chk("b2b_rd_rdata", bus.rsp_rdata, 32'hA5C30F96);
    for (int t = 0; t < 200; t++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 9) == 0 ? 32'(4096 - $urandom_range(1, 4)) : 32'($urandom_range(0, 4095));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er);
    end
    do_req(1, 2, 0, 32'h4, 32'hDEADBEEF, rd, er);
    // request held valid across a clear is accepted as soon as the clear ends
    @(negedge Clk);
    clr_start = 1; bus.req_valid = 1; bus.req_we = 0; bus.req_size = 2; bus.req_signed = 0;
    bus.req_addr = 32'h4;
    @(posedge Clk); #1 clr_start = 0;
    n = 0; bad = 0;
    while (clr_busy && n < 2000) begin n++; if (bus.req_ready) bad = 1; @(posedge Clk); #1; end
    chk("clr2_cycles", n, 512);
    chk("clr2_ready_low", bad, 0);
    chk("clr2_ready_after", bus.req_ready, 1);
    @(posedge Clk); #1 bus.req_valid = 0;
    chk("held_rsp_valid", bus.rsp_valid, 1);
    chk("held_rsp_rdata", bus.rsp_rdata, 0);
    for (int i = 0; i < 4096; i++) mm[i] = 0;
    // reset during a clear leaves untouched entries intact
    v600 = $urandom | 32'h1;
    do_req(1, 2, 0, 32'h0, 32'h12345678, rd, er);
    do_req(1, 2, 0, 32'h960, v600, rd, er);
    @(negedge Clk) clr_start = 1;
    @(posedge Clk); #1 clr_start = 0;
    n = 0;
    while (clr_busy && n < 100) begin n++; @(posedge Clk); #1; end
    chk("clr3_reach100", n, 100);
    @(negedge Clk) Reset = 1;
    @(posedge Clk); #1;
    chk("rst_mid_busy", clr_busy, 0);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    Reset = 0;
    for (int i = 0; i < 4; i++) mm[i] = 0;
    do_req(0, 2, 0, 32'h0, 0, rd, er); chk("rst_mid_entry0", rd, 0);
    do_req(0, 2, 0, 32'h960, 0, rd, er); chk("rst_mid_entry600", rd, v600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
